// File: rtl/video_mode_sequencer.sv
// video_mode_sequencer: sequences a raster mode change. It waits for a frame
// boundary, blanks video and holds the timing generator, then switches the
// mode-table select and has the pixel PLL reconfigured. After lock it releases
// the timing hold and lets a few clean frames pass before unblanking.
module video_mode_sequencer #(
  parameter int MODE_W        = 3,
  parameter int RESET_MODE    = 0,
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int EOF_TIMEOUT   = 1 << 22
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode_req,
  input  logic [MODE_W-1:0] mode_index,
  input  logic              force_req,   // "force" is a reserved word, hence the suffix
  input  logic              frame_start,
  input  logic              pll_done,
  output logic [MODE_W-1:0] mode_sel,
  output logic              timing_hold,
  output logic              blank,
  output logic              pll_req,
  output logic              busy,
  output logic              mode_ack,
  output logic              timeout_flag
);

  // Counter widths: each counter only ever has to reach its own last value.
  localparam int TMO_W   = (EOF_TIMEOUT > 1) ? $clog2(EOF_TIMEOUT) : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int FRAME_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'((EOF_TIMEOUT > 0) ? EOF_TIMEOUT - 1 : 0);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SETTLE_FRAMES);
  localparam logic [MODE_W-1:0]  MODE_RST   = MODE_W'(RESET_MODE);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EOF,
    SWITCH,
    PLL_WAIT,
    HOLD,
    SETTLE
  } state_t;

  state_t              state, state_next;
  logic [MODE_W-1:0]   mode_sel_next, target, target_next;
  logic [MODE_W-1:0]   pending_index, pending_index_next;
  logic                pending_force, pending_force_next;
  logic                pending_valid, pending_valid_next;
  logic                timing_hold_next, blank_next, pll_req_next;
  logic                mode_ack_next, timeout_flag_next;
  logic                pll_armed, pll_armed_next;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_next;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
  logic [FRAME_W-1:0]  frame_cnt, frame_cnt_next;

  assign busy = (state != IDLE);

  // State and output registers; reset drops everything, including any pending request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mode_sel      <= MODE_RST;
      target        <= MODE_RST;
      pending_index <= '0;
      pending_force <= 1'b0;
      pending_valid <= 1'b0;
      timing_hold   <= 1'b0;
      blank         <= 1'b0;
      pll_req       <= 1'b0;
      mode_ack      <= 1'b0;
      timeout_flag  <= 1'b0;
      pll_armed     <= 1'b0;
      tmo_cnt       <= '0;
      hold_cnt      <= '0;
      frame_cnt     <= '0;
    end else begin
      state         <= state_next;
      mode_sel      <= mode_sel_next;
      target        <= target_next;
      pending_index <= pending_index_next;
      pending_force <= pending_force_next;
      pending_valid <= pending_valid_next;
      timing_hold   <= timing_hold_next;
      blank         <= blank_next;
      pll_req       <= pll_req_next;
      mode_ack      <= mode_ack_next;
      timeout_flag  <= timeout_flag_next;
      pll_armed     <= pll_armed_next;
      tmo_cnt       <= tmo_cnt_next;
      hold_cnt      <= hold_cnt_next;
      frame_cnt     <= frame_cnt_next;
    end
  end

  // Next-state logic: mode-change sequence, lock-loss recovery, then request capture (which always wins).
  always_comb begin
    state_next         = state;
    mode_sel_next      = mode_sel;
    target_next        = target;
    pending_index_next = pending_index;
    pending_force_next = pending_force;
    pending_valid_next = pending_valid;
    timing_hold_next   = timing_hold;
    blank_next         = blank;
    pll_req_next       = pll_req;
    mode_ack_next      = 1'b0;
    timeout_flag_next  = timeout_flag;
    pll_armed_next     = pll_armed;
    tmo_cnt_next       = tmo_cnt;
    hold_cnt_next      = hold_cnt;
    frame_cnt_next     = frame_cnt;

    case (state)
      IDLE: begin
        if (pending_valid) begin
          pending_valid_next = 1'b0;
          if (pending_force || (pending_index != mode_sel)) begin
            timeout_flag_next = 1'b0;
            target_next       = pending_index;
            tmo_cnt_next      = '0;
            state_next        = WAIT_EOF;
          end else begin
            mode_ack_next = 1'b1;
          end
        end
      end
      WAIT_EOF: begin
        // The counter leaves this state at TMO_LAST, so it can never wrap.
        if (frame_start || (tmo_cnt == TMO_LAST)) begin
          if (!frame_start) timeout_flag_next = 1'b1;
          blank_next       = 1'b1;
          timing_hold_next = 1'b1;
          tmo_cnt_next     = '0;
          state_next       = SWITCH;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end
      SWITCH: begin
        mode_sel_next  = target;
        pll_req_next   = 1'b1;
        pll_armed_next = 1'b0;
        state_next     = PLL_WAIT;
      end
      PLL_WAIT: begin
        // The first cycle may still show the old lock, so it is skipped.
        if (!pll_armed) begin
          pll_armed_next = 1'b1;
        end else if (pll_done) begin
          pll_req_next  = 1'b0;
          hold_cnt_next = '0;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt >= HOLD_LAST) begin
          timing_hold_next = 1'b0;
          frame_cnt_next   = '0;
          state_next       = SETTLE;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (frame_cnt >= FRAME_LAST) begin
          blank_next    = 1'b0;
          mode_ack_next = 1'b1;
          state_next    = IDLE;
        end else if (frame_start) begin
          frame_cnt_next = frame_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (((state == HOLD) || (state == SETTLE)) && !pll_done) begin
      timing_hold_next = 1'b1;
      pll_req_next     = 1'b1;
      blank_next       = 1'b1;
      mode_ack_next    = 1'b0;
      pll_armed_next   = 1'b0;
      hold_cnt_next    = '0;
      frame_cnt_next   = '0;
      state_next       = PLL_WAIT;
    end

    if (mode_req) begin
      pending_index_next = mode_index;
      pending_force_next = force_req;
      pending_valid_next = 1'b1;
    end
  end

endmodule

// File: doc/video_mode_sequencer.md
Name: video_mode_sequencer

Overview:
- Controls mode changes for the raster timing generator. It takes mode-change requests, waits for a frame boundary, blanks video, holds the timing counters, requests pixel-PLL reconfiguration, and switches the mode-table select.
- After the PLL confirms, it waits a set number of clean frames before unblanking.
- It sits between the configuration/OSD logic and the mode table that feeds the timing generator's videoMode input.

Parameters:
- MODE_W, 3, width of the mode index.
- RESET_MODE, 0, mode index selected out of reset.
- HOLD_CYCLES, 16, clocks the timing hold stays asserted after pll_done, before release.
- SETTLE_FRAMES, 2, frame_start pulses counted with blank still high after release.
- EOF_TIMEOUT, 2^22, clocks to wait for frame_start before forcing the switch.

Ports:
- clock  in  1  pixel-domain clock.
- reset  in  1  asynchronous, active-high reset.
- mode_req  in  1  single-cycle request strobe.
- mode_index  in  MODE_W  requested mode, sampled when mode_req=1.
- force  in  1  sampled with mode_req; 1 means switch even if the index equals the current mode.
- frame_start  in  1  pulse from the timing side when counterX==0 and counterY==0.
- pll_done  in  1  level signal; 1 means the PLL is reconfigured and locked for the current mode_sel.
- mode_sel  out  MODE_W  registered mode-table select.
- timing_hold  out  1  holds timing-generator counters and state at 0.
- blank  out  1  forces pixel data to black and suppresses DE.
- pll_req  out  1  level request to reconfigure the PLL for mode_sel.
- busy  out  1  high in every state except IDLE.
- mode_ack  out  1  one-cycle pulse when a switch completes.
- timeout_flag  out  1  sticky; set when EOF_TIMEOUT expires; cleared by the next accepted request.

Behaviour:
- Reset is asynchronous, active-high. Values on reset: state=IDLE, mode_sel=RESET_MODE, timing_hold=0, blank=0, pll_req=0, busy=0, mode_ack=0, timeout_flag=0, pending_valid=0, all counters 0.
- Request latching:
  - mode_req=1 in any state writes pending_index and pending_force and sets pending_valid.
  - The last request wins. pending_valid is set in the same edge as the request.
- IDLE:
  - If pending_valid=1 and (pending_force=1 or pending_index!=mode_sel): clear pending_valid and timeout_flag, latch target=pending_index, go to WAIT_EOF. busy rises on the next cycle.
  - If pending_valid=1 and the index equals mode_sel without force: clear pending_valid, pulse mode_ack for one cycle, stay in IDLE.
- WAIT_EOF:
  - A timeout counter increments every clock.
  - On frame_start=1: blank<=1, timing_hold<=1, go to SWITCH.
  - If the counter reaches EOF_TIMEOUT-1 first: set timeout_flag, and take the same transition.
  - blank and timing_hold are asserted no earlier than the edge that samples frame_start.
- SWITCH (one cycle): mode_sel<=target, pll_req<=1, go to PLL_WAIT.
- PLL_WAIT:
  - pll_done is ignored during the first cycle of PLL_WAIT, so the previous lock is not taken as the new one.
  - From the second cycle, pll_done=1 clears pll_req and goes to HOLD.
- HOLD:
  - Count HOLD_CYCLES clocks.
  - On the last count, timing_hold<=0 and go to SETTLE with the frame counter at 0.
- SETTLE:
  - blank stays 1. Each frame_start increments the frame counter.
  - When the count reaches SETTLE_FRAMES: blank<=0, mode_ack pulses for one cycle, go to IDLE.
  - SETTLE_FRAMES=0 means exit on the first SETTLE cycle.
- Loss of lock: if pll_done falls in HOLD or SETTLE, set timing_hold=1 and pll_req=1, go to PLL_WAIT, and restart all counts (blank stays 1).
- Requests while busy: the request is only latched. It is serviced from IDLE on the cycle after mode_ack, so a completed switch is never aborted.
- Counter widths:
  - The timeout counter is clog2(EOF_TIMEOUT) bits.
  - The other counters are sized for their parameter.
  - Counters saturate and never wrap.
- Reset mid-operation returns every output to its reset value immediately and discards any pending request.

Test Plan:
- Reset release, then mode_req with mode_index=3 and frame_start every 1000 clocks:
  - Nothing changes before frame_start.
  - The edge after frame_start gives blank=1 and timing_hold=1; the next edge gives mode_sel=3 and pll_req=1.
  - pll_done held high throughout gives a release 16 clocks after the PLL_WAIT exit.
  - mode_ack pulses after 2 further frame_starts, with blank=0 on that cycle.
- mode_req with index=0 equal to mode_sel and force=0: one mode_ack pulse 1 cycle later, busy never rises, blank never rises. Repeat with force=1: full sequence runs.
- Request index=5 while in PLL_WAIT for index=3: the first switch completes (mode_ack, mode_sel=3), then busy rises again on the following cycle and mode_sel becomes 5.
- frame_start held at 0: after EOF_TIMEOUT clocks timeout_flag=1 and the switch proceeds; the next accepted request clears timeout_flag.
- pll_done dropped for 1 cycle during SETTLE: timing_hold and pll_req reassert, blank stays 1, and mode_ack is delayed until a full new HOLD plus 2 frames completes.
- reset asserted asynchronously in HOLD: all outputs return to reset values without waiting for a clock edge, mode_sel=RESET_MODE, and no mode_ack pulse occurs.
